// File: rtl/timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_ctrl_pkg
// Shared types and constants for the interval-timer controller.
//   state_t      : controller phase (IDLE, RUN, PAUSE, DONE)
//   MODE_ONESHOT : stop in DONE after the terminal tick
//   MODE_RELOAD  : reload the counter and keep running after the terminal tick
// -----------------------------------------------------------------------------
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage : timer_ctrl_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock by div+1 while enabled. The internal counter holds its
// value while en is low, so a paused timer resumes mid-prescale.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   clr        : restart the prescale interval (wins over en)
//   div        : divisor minus one
//   tick       : combinational strobe, high in the enabled cycle that ends an
//                interval
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PRE_W'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Programmable interval timer: a WIDTH-bit down-counter stepped by a prescaled
// tick, with one-shot / auto-reload modes, a one-cycle terminal strobe and a
// sticky interrupt.
// Ports:
//   cfg_load/cfg_value/cfg_pre/cfg_mode : configuration latch (not in RUN)
//   start / stop / clear                : command pulses (clear > stop > start
//                                         > cfg_load)
//   irq_ack                             : clears irq
//   count                               : current counter value
//   busy                                : registered, high while in RUN
//   tc_pulse                            : one-cycle strobe on the terminal tick
//   irq                                 : sticky terminal-count interrupt
// -----------------------------------------------------------------------------
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             irq
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic [PRE_W-1:0] pre_reg;
    logic             mode_reg;

    // Commands that actually take effect, already resolved by priority.
    logic do_clear, do_stop, do_start, do_load;
    logic fresh_start;
    logic tick, terminal;

    assign do_clear    = clear;
    assign do_stop     = !do_clear && stop && (state == RUN);
    assign do_start    = !do_clear && !do_stop && start &&
                         ((state == PAUSE) ||
                          (((state == IDLE) || (state == DONE)) && (reload != '0)));
    assign do_load     = !do_clear && !do_stop && !do_start && cfg_load && (state != RUN);
    assign fresh_start = do_start && (state != PAUSE);

    // The prescaler is held on the stop edge too, so a tick due at that edge
    // is not lost and a resumed run consumes exactly the remaining ticks.
    tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    ((state == RUN) && !clear && !stop),
        .clr   (do_clear || fresh_start || do_load),
        .div   (pre_reg),
        .tick  (tick)
    );

    assign terminal = tick && (count == WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (do_clear) begin
            state_next = IDLE;
        end else if (do_stop) begin
            state_next = PAUSE;
        end else if (do_start) begin
            state_next = RUN;
        end else if (terminal && (mode_reg == MODE_ONESHOT)) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            reload   <= '0;
            pre_reg  <= '0;
            mode_reg <= MODE_ONESHOT;
            busy     <= 1'b0;
            tc_pulse <= 1'b0;
            irq      <= 1'b0;
        end else begin
            busy     <= (state_next == RUN);
            tc_pulse <= terminal;

            if (do_clear) begin
                irq <= 1'b0;
            end else if (terminal) begin
                irq <= 1'b1;            // set wins over a same-cycle ack
            end else if (irq_ack) begin
                irq <= 1'b0;
            end

            if (do_clear) begin
                count <= reload;
            end else if (fresh_start) begin
                count <= reload;
            end else if (do_load) begin
                reload   <= cfg_value;
                pre_reg  <= cfg_pre;
                mode_reg <= cfg_mode;
                count    <= cfg_value;
            end else if (tick) begin
                if (count != WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else if (mode_reg == MODE_RELOAD) begin
                    count <= reload;
                end else begin
                    count <= '0;
                end
            end
        end
    end

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Self-checking bench for timer_ctrl (WIDTH=4, PRE_W=4). Each step drives one
// cycle of inputs, pushes the outputs expected after the next rising edge onto
// a scoreboard queue, and pops/compares them 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [3:0] cfg_value;
    logic [3:0] cfg_pre;
    logic       cfg_mode;
    logic       start, stop, clear, irq_ack;
    logic [3:0] count;
    logic       busy, tc_pulse, irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic [3:0] val;
        logic [3:0] pre;
        logic       mode;
        logic       st;
        logic       sp;
        logic       cl;
        logic       ack;
        logic [3:0] e_count;
        logic       e_busy;
        logic       e_tc;
        logic       e_irq;
    } vec_t;

    typedef struct {
        logic [3:0] count;
        logic       busy;
        logic       tc;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    timer_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_value (cfg_value),
        .cfg_pre   (cfg_pre),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .irq_ack   (irq_ack),
        .count     (count),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [3:0] val, input logic [3:0] pre,
                                input logic mode, input logic st, input logic sp,
                                input logic cl, input logic ack, input logic [3:0] ec,
                                input logic eb, input logic et, input logic ei);
        vec_t v;
        v.ld = ld; v.val = val; v.pre = pre; v.mode = mode;
        v.st = st; v.sp = sp; v.cl = cl; v.ack = ack;
        v.e_count = ec; v.e_busy = eb; v.e_tc = et; v.e_irq = ei;
        return v;
    endfunction

    // Idle cycle (no commands) with expected outputs.
    function automatic vec_t nop(input logic [3:0] ec, input logic eb, input logic et,
                                 input logic ei);
        return mk(0, 4'd0, 4'd0, 0, 0, 0, 0, 0, ec, eb, et, ei);
    endfunction

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        cfg_load  = v.ld;
        cfg_value = v.val;
        cfg_pre   = v.pre;
        cfg_mode  = v.mode;
        start     = v.st;
        stop      = v.sp;
        clear     = v.cl;
        irq_ack   = v.ack;
        sb.push_back('{count: v.e_count, busy: v.e_busy, tc: v.e_tc, irq: v.e_irq});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".count"}, 32'(count),    32'(e.count));
        check({tag, ".busy"},  32'(busy),     32'(e.busy));
        check({tag, ".tc"},    32'(tc_pulse), 32'(e.tc));
        check({tag, ".irq"},   32'(irq),      32'(e.irq));
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_load = 0; cfg_value = 0; cfg_pre = 0; cfg_mode = 0;
        start = 0; stop = 0; clear = 0; irq_ack = 0;

        // One-shot, value 3, pre 0: counts 2,1,0 after edges 1..3, terminal at 3.
        tbl.push_back(mk(1, 4'd3, 4'd0, 0, 0, 0, 0, 0, 4'd3, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd3, 1, 0, 0));
        tbl.push_back(nop(4'd2, 1, 0, 0));
        tbl.push_back(nop(4'd1, 1, 0, 0));
        tbl.push_back(nop(4'd0, 0, 1, 1));
        tbl.push_back(nop(4'd0, 0, 0, 1));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0));
        // Back to IDLE, then reload 0: start must be ignored.
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 4'd3, 0, 0, 0));
        tbl.push_back(mk(1, 4'd0, 4'd0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(nop(4'd0, 0, 0, 0));
        // Auto-reload 2/pre 0, reach a terminal, then start+stop+clear together.
        tbl.push_back(mk(1, 4'd2, 4'd0, 1, 0, 0, 0, 0, 4'd2, 0, 0, 0));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd2, 1, 0, 0));
        tbl.push_back(nop(4'd1, 1, 0, 0));
        tbl.push_back(nop(4'd2, 1, 1, 1));
        tbl.push_back(nop(4'd1, 1, 0, 1));
        tbl.push_back(mk(0, 4'd0, 4'd0, 0, 1, 1, 1, 0, 4'd2, 0, 0, 0));
        tbl.push_back(nop(4'd2, 0, 0, 0));

        #2;
        check("reset.count", 32'(count),    32'd0);
        check("reset.busy",  32'(busy),     32'd0);
        check("reset.tc",    32'(tc_pulse), 32'd0);
        check("reset.irq",   32'(irq),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Auto-reload value 2, pre 2: tc every 6 clocks; ack at edge 8 clears,
        // ack coinciding with the terminal tick at edge 12 loses to the set.
        step(mk(1, 4'd2, 4'd2, 1, 0, 0, 0, 0, 4'd2, 0, 0, 0), "ar.load");
        step(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd2, 1, 0, 0), "ar.start");
        for (int e = 1; e <= 13; e++) begin
            logic ack_now, exp_irq;
            ack_now = (e == 8) || (e == 12);
            exp_irq = (e == 6) || (e == 7) || (e >= 12);
            step(mk(0, 4'd0, 4'd0, 0, 0, 0, 0, ack_now,
                    ((e / 3) % 2 == 1) ? 4'd1 : 4'd2, 1, (e % 6 == 0), exp_irq),
                 $sformatf("ar.e%0d", e));
        end
        step(mk(0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 4'd2, 0, 0, 0), "ar.clear");

        // Pause/resume: value 5, pre 1, one-shot. Stop at edge 3, resume at 14;
        // ten RUN clocks in total put the terminal tick at edge 22.
        step(mk(1, 4'd5, 4'd1, 0, 0, 0, 0, 0, 4'd5, 0, 0, 0), "pz.load");
        step(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd5, 1, 0, 0), "pz.start");
        step(nop(4'd5, 1, 0, 0), "pz.e1");
        step(nop(4'd4, 1, 0, 0), "pz.e2");
        step(mk(0, 4'd0, 4'd0, 0, 0, 1, 0, 0, 4'd4, 0, 0, 0), "pz.stop");
        for (int e = 4; e <= 13; e++) step(nop(4'd4, 0, 0, 0), $sformatf("pz.hold%0d", e));
        step(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd4, 1, 0, 0), "pz.resume");
        for (int e = 15; e <= 21; e++)
            step(nop(4'(4 - (e - 14) / 2), 1, 0, 0), $sformatf("pz.e%0d", e));
        step(nop(4'd0, 0, 1, 1), "pz.term");
        step(nop(4'd0, 0, 0, 1), "pz.after");

        // cfg_load in RUN is ignored, then reset is dropped mid-run.
        step(mk(1, 4'd6, 4'd3, 1, 0, 0, 0, 0, 4'd6, 0, 0, 1), "rs.load");
        step(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd6, 1, 0, 1), "rs.start");
        step(mk(1, 4'd2, 4'd0, 0, 0, 0, 0, 0, 4'd6, 1, 0, 1), "rs.load_in_run");
        step(nop(4'd6, 1, 0, 1), "rs.run");
        #2;
        rst_n = 1'b0;
        #1;
        check("rs.async.count", 32'(count),    32'd0);
        check("rs.async.busy",  32'(busy),     32'd0);
        check("rs.async.tc",    32'(tc_pulse), 32'd0);
        check("rs.async.irq",   32'(irq),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reload is 0 again after reset, so start does nothing.
        step(mk(0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 0), "rs.start_after");

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule : tb_timer_ctrl
